// File: rtl/sti_pkg.sv
// Shared definitions for the serial-transmit receive path: word width,
// frame length encodings, FSM states and the FIFO entry layout.
package sti_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] LEN_8  = 2'd0;
    localparam logic [1:0] LEN_16 = 2'd1;
    localparam logic [1:0] LEN_24 = 2'd2;
    localparam logic [1:0] LEN_32 = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0]        len;
        logic [DATA_W-1:0] data;
    } entry_t;

    function automatic logic [5:0] len_bits(input logic [1:0] len);
        case (len)
            LEN_8:   return 6'd8;
            LEN_16:  return 6'd16;
            LEN_24:  return 6'd24;
            default: return 6'd32;
        endcase
    endfunction

    // Keeps the low len_bits(len) bits of a word.
    function automatic logic [DATA_W-1:0] len_mask(input logic [1:0] len);
        case (len)
            LEN_8:   return 32'h0000_00FF;
            LEN_16:  return 32'h0000_FFFF;
            LEN_24:  return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/sti_rx_deser_if.sv
// Word delivery handshake from the deserializer to the checker/memory-writer:
// the deserializer is the master (drives data/valid), downstream is the slave.
interface sti_rx_deser_if;
    import sti_pkg::*;

    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_len;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_len,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_len,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sti_rx_fifo.sv
// Synchronous FIFO with a fall-through head; DEPTH must be a power of 2 (>= 2).
// While empty the head shows the last word popped.
module sti_rx_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? hold_q : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            hold_d   = mem_q[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/sti_rx_deser.sv
// Serial-to-parallel receiver: frames of 8/16/24/32 valid bits are assembled
// into right-aligned words and queued for downstream. STI_RX_STAT_EN adds counters.
module sti_rx_deser
    import sti_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 si_data,
    input  logic                 si_valid,
    input  logic [1:0]           cfg_length,
    input  logic                 cfg_msb,
    sti_rx_deser_if.master       out_if,
    output logic                 frame_err,
    output logic                 overflow,
    output logic                 busy
`ifdef STI_RX_STAT_EN
    ,
    output logic [15:0]          frame_cnt,
    output logic [7:0]           err_cnt
`endif
);

    state_e            state_q, state_d;
    logic [5:0]        count_q, count_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_next;
    logic [1:0]        len_q, len_d;
    logic              msb_q, msb_d;
    logic              push_q, push_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [1:0]        wlen_q, wlen_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;

    entry_t            wr_entry, head_entry;
    logic              fifo_full, fifo_empty, pop;

    assign pop = !fifo_empty && out_if.out_ready;

    always_comb begin
        shift_next = shift_q;
        if (msb_q) begin
            shift_next = {shift_q[DATA_W-2:0], si_data};
        end else begin
            shift_next[count_q[4:0]] = si_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        len_d       = len_q;
        msb_d       = msb_q;
        push_d      = 1'b0;
        word_d      = word_q;
        wlen_d      = wlen_q;
        frame_err_d = 1'b0;
        // The completed word reaches the FIFO one edge after its last bit.
        overflow_d  = push_q && fifo_full && !pop;

        case (state_q)
            ST_IDLE: begin
                if (si_valid) begin
                    len_d   = cfg_length;
                    msb_d   = cfg_msb;
                    shift_d = {{(DATA_W-1){1'b0}}, si_data};
                    count_d = 6'd1;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                if (si_valid) begin
                    shift_d = shift_next;
                    count_d = count_q + 6'd1;
                    if (count_q + 6'd1 == len_bits(len_q)) begin
                        push_d  = 1'b1;
                        word_d  = shift_next & len_mask(len_q);
                        wlen_d  = len_q;
                        count_d = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    count_d     = '0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            shift_q     <= '0;
            len_q       <= LEN_8;
            msb_q       <= 1'b0;
            push_q      <= 1'b0;
            word_q      <= '0;
            wlen_q      <= LEN_8;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            msb_q       <= msb_d;
            push_q      <= push_d;
            word_q      <= word_d;
            wlen_q      <= wlen_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wr_entry.len  = wlen_q;
    assign wr_entry.data = word_q;

    sti_rx_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .pop   (pop),
        .wdata (wr_entry),
        .head  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_if.out_data  = head_entry.data;
    assign out_if.out_len   = head_entry.len;
    assign out_if.out_valid = !fifo_empty;
    assign frame_err        = frame_err_q;
    assign overflow         = overflow_q;
    assign busy             = (state_q == ST_SHIFT);

`ifdef STI_RX_STAT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [8:0]  err_sum;
    logic        push_ok;

    assign push_ok = push_q && (!fifo_full || pop);

    // Coincident frame error and overflow add two; both counters stick at all-ones.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (push_ok && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        err_sum   = {1'b0, err_cnt_q} + {8'd0, frame_err_d} + {8'd0, overflow_d};
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_sti_rx_deser.sv
// Directed bench for sti_rx_deser: stimulus queues expected words, a monitor
// pops and compares them whenever the DUT hands a word downstream.
module tb_sti_rx_deser;
    import sti_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       si_data;
    logic       si_valid;
    logic [1:0] cfg_length;
    logic       cfg_msb;
    logic       frame_err;
    logic       overflow;
    logic       busy;
`ifdef STI_RX_STAT_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    sti_rx_deser_if bus ();

    sti_rx_deser #(.FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .si_data    (si_data),
        .si_valid   (si_valid),
        .cfg_length (cfg_length),
        .cfg_msb    (cfg_msb),
        .out_if     (bus),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .busy       (busy)
`ifdef STI_RX_STAT_EN
        ,
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    int     ferr_pulses = 0;
    int     ovf_pulses  = 0;
    entry_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) ferr_pulses++;
            if (overflow)  ovf_pulses++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got word 0x%0h with nothing expected", bus.out_data);
                end else begin
                    entry_t e;
                    e = exp_q.pop_front();
                    check("sb_data", bus.out_data, e.data);
                    check("sb_len", {30'd0, bus.out_len}, {30'd0, e.len});
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        si_valid = 1'b1;
        si_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        si_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [1:0] len, input logic msb, input logic [31:0] val,
                              input bit expect_push, input bit idle_after);
        int     n;
        entry_t e;
        n = 8 * (int'(len) + 1);
        cfg_length = len;
        cfg_msb    = msb;
        if (expect_push) begin
            e.len  = len;
            e.data = (n == 32) ? val : (val & ((32'h1 << n) - 32'h1));
            exp_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            send_bit(msb ? val[n-1-i] : val[i]);
        end
        if (idle_after) si_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        si_data       = 1'b0;
        si_valid      = 1'b0;
        cfg_length    = LEN_8;
        cfg_msb       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {30'd0, frame_err, overflow}, 32'd0);
        @(posedge clk);
        #1;

        // 8-bit MSB-first 1,0,1,1,0,0,1,0 -> 0xB2; check push latency.
        bus.out_ready = 1'b1;
        send_frame(LEN_8, 1'b1, 32'h0000_00B2, 1'b1, 1'b1);
        @(negedge clk);
        check("lat_not_yet", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("lat_valid", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk);
        #1;
        idle(1);

        // 16-bit LSB-first, then MSB-first, then 24-bit LSB-first with one-cycle gaps.
        send_frame(LEN_16, 1'b0, 32'h0000_A5C3, 1'b1, 1'b1);
        idle(1);
        send_frame(LEN_16, 1'b1, 32'h0000_A5C3, 1'b1, 1'b1);
        idle(1);
        send_frame(LEN_24, 1'b0, 32'hFF12_3456, 1'b1, 1'b1);
        idle(4);
        check("drain_a", exp_q.size(), 32'd0);

        // Truncated 32-bit frame after 20 bits.
        cfg_length = LEN_32;
        cfg_msb    = 1'b1;
        for (int i = 0; i < 20; i++) send_bit(i[0]);
        si_valid = 1'b0;
        @(negedge clk);
        check("trunc_busy_hi", {31'd0, busy}, 32'd1);
        check("trunc_err_lo", {31'd0, frame_err}, 32'd0);
        @(negedge clk);
        check("trunc_err_hi", {31'd0, frame_err}, 32'd1);
        check("trunc_busy_lo", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("trunc_err_once", {31'd0, frame_err}, 32'd0);
        check("trunc_no_push", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        send_frame(LEN_32, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        idle(4);

        // Back-to-back frames into a stalled FIFO: third one overflows.
        bus.out_ready = 1'b0;
        send_frame(LEN_8, 1'b1, 32'h11, 1'b1, 1'b0);
        send_frame(LEN_8, 1'b1, 32'h22, 1'b1, 1'b0);
        send_frame(LEN_8, 1'b1, 32'h33, 1'b0, 1'b1);
        @(negedge clk);
        check("ovf_lo", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        check("ovf_hi", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        check("ovf_once", {31'd0, overflow}, 32'd0);
        check("ovf_head", bus.out_data, 32'h11);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        idle(4);
        check("drain_b", exp_q.size(), 32'd0);
        @(negedge clk);
        check("empty_valid", {31'd0, bus.out_valid}, 32'd0);
        check("empty_hold", bus.out_data, 32'h22);
        @(posedge clk);
        #1;

        // Full FIFO with a pop on the same edge as the third push.
        bus.out_ready = 1'b0;
        send_frame(LEN_8, 1'b1, 32'h44, 1'b1, 1'b0);
        send_frame(LEN_8, 1'b0, 32'h55, 1'b1, 1'b0);
        send_frame(LEN_8, 1'b1, 32'h66, 1'b1, 1'b1);
        bus.out_ready = 1'b1;
        idle(6);
        check("drain_c", exp_q.size(), 32'd0);

        // Reset mid-frame with a word waiting in the FIFO.
        bus.out_ready = 1'b0;
        send_frame(LEN_8, 1'b1, 32'h77, 1'b1, 1'b1);
        cfg_length = LEN_16;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_data", bus.out_data, 32'd0);
        check("mid_rst_len", {30'd0, bus.out_len}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_flags", {30'd0, frame_err, overflow}, 32'd0);
        exp_q.delete();
        si_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        idle(2);

        // Config change mid-frame is ignored: 8-bit MSB-first 0x5A.
        cfg_length = LEN_8;
        cfg_msb    = 1'b1;
        exp_q.push_back('{len: LEN_8, data: 32'h5A});
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        cfg_length = LEN_32;
        cfg_msb    = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        si_valid = 1'b0;
        @(negedge clk);
        check("latch_busy_lo", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        idle(5);

        check("drain_end", exp_q.size(), 32'd0);
        check("ferr_total", ferr_pulses, 32'd1);
        check("ovf_total", ovf_pulses, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sti_rx_deser.md
Name: sti_rx_deser

Overview:
- Serial-to-parallel receiver sitting directly downstream of the serial transmit interface.
- Consumes the 1-bit serial stream plus its valid strobe, and re-assembles each frame into a right-aligned 32-bit word.
- Frame length and bit order are configurable.
- Completed words are buffered in a small FIFO and delivered over a valid/ready handshake to the checker/memory-writer stage.

Parameters:
- FIFO_DEPTH, 2, output buffer entries; power of 2, minimum 2.
- DATA_W, 32, output word width; fixed, maximum frame length.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- si_data  in  1  serial data bit.
- si_valid  in  1  si_data valid this cycle; frame is a run of valid bits.
- cfg_length  in  2  frame length: 0=8, 1=16, 2=24, 3=32 bits.
- cfg_msb  in  1  1 = first received bit is the word MSB; 0 = first bit is bit 0.
- out_data  out  32  head word, right-aligned, unused upper bits zero.
- out_len  out  2  cfg_length latched for the head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accepts head word when out_valid&&out_ready.
- frame_err  out  1  one-cycle pulse: frame truncated.
- overflow  out  1  one-cycle pulse: completed frame dropped, FIFO full.
- busy  out  1  high while in SHIFT.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, bit counter 0, shift register 0.
- Reset mid-frame discards partial data; FIFO contents are lost.
- FSM states:
  - IDLE: on si_valid=1, capture the first bit and latch cfg_length/cfg_msb into frame registers. Set count=1, go SHIFT. If N==1 is impossible (min 8), stay in SHIFT.
  - SHIFT, si_valid=1: capture bit, count+1.
  - SHIFT, count reaches N (the Nth bit is captured this cycle): frame complete, push word, go IDLE.
  - SHIFT, si_valid=0 before N bits: pulse frame_err next cycle, discard word, go IDLE.
- Back-to-back frames:
  - si_valid high the cycle after completion starts a new frame in IDLE with no gap required.
  - A single low cycle between frames is normal and not an error.
- Bit placement:
  - MSB-first: shift = {shift[30:0], bit}; after N bits the word sits in [N-1:0].
  - LSB-first: bit k (k = 0..N-1, arrival order) is written to position k.
  - Bits [31:N] are forced to 0 on push.
- Config changes during SHIFT are ignored; they take effect at the next frame start.
- Push/pop latency:
  - Word pushed at cycle t (Nth bit sampled at edge t) → out_valid=1 and out_data valid after edge t+1 when the FIFO was empty.
  - out_data/out_len are head-of-FIFO (fall-through from registered storage).
  - A pop occurs on a cycle with out_valid&&out_ready; the head advances on the following edge.
- FIFO full:
  - A push with no simultaneous pop drops the word and pulses overflow one cycle.
  - Push and pop in the same cycle when full: both are accepted, and occupancy is unchanged.
- FIFO empty: out_ready is ignored, out_data holds its last value, out_valid=0.
- Pointers wrap modulo FIFO_DEPTH; the count register is log2(FIFO_DEPTH)+1 bits wide.
- frame_err and overflow may pulse in the same cycle only if independent events coincide; both are reported.

Optional Feature:
- Macro: STI_RX_STAT_EN.
- Defined:
  - Adds output frame_cnt[15:0], counting words successfully pushed.
  - Adds output err_cnt[7:0], counting frame_err plus overflow events (both increments when coincident).
  - Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package sti_pkg:
  - Length encoding constants LEN_8/LEN_16/LEN_24/LEN_32 (2'd0..2'd3).
  - Function len_bits(len) returning 8/16/24/32.
  - DATA_W constant.
- Sub-module sti_rx_fifo: parameterised synchronous FIFO with push/pop/full/empty and a fall-through head.
- FSM and shifter stay in the top.

Test Plan:
- 8-bit, MSB-first: cfg_length=0, cfg_msb=1, send bits 1,0,1,1,0,0,1,0 → out_valid one cycle after last bit, out_data=32'h000000B2, out_len=0.
- 16-bit, LSB-first: cfg_length=1, cfg_msb=0, send 16'hA5C3 bit0 first → out_data=32'h0000A5C3. Repeat with cfg_msb=1 (MSB first) → same value.
- Truncation: cfg_length=3, drop si_valid after 20 bits → frame_err pulses exactly one cycle, no push, busy falls; the next 32-bit frame is received correctly.
- Back-to-back plus backpressure: three 8-bit frames 0x11, 0x22, 0x33 with no gaps, out_ready=0 → 0x11 and 0x22 buffered, overflow pulse on the third. Then out_ready=1 → 0x11 then 0x22 popped.
- Full with simultaneous pop: FIFO holds 2 words, out_ready=1 on the cycle the third frame completes → no overflow, output order preserved.
- Reset mid-frame plus config latch: assert reset after 5 bits → all outputs 0. Change cfg_length mid-frame → ignored; the frame length follows the latched value.
